// File: rtl/router_link_pkg.sv
// Shared types for router link endpoints: flit type, credit counter width helper, tx FSM states.
package router_link_pkg;

  localparam int unsigned FLIT_W = 64;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic [1:0] {
    TX_INIT,
    TX_RUN,
    TX_BLOCKED
  } tx_state_t;

  // One extra bit so the counter can hold buffer_depth-1 for any depth.
  function automatic int unsigned credit_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Free-slot counter for the downstream buffer: decrements on send, increments on credit return,
// saturates at DEPTH-1 and flags the overflow attempt.
module credit_counter
  import router_link_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned W     = credit_w(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dec_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic         zero_next_o,
  output logic         ovf_o
);

  localparam logic [W-1:0] MAX = W'(DEPTH - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    count_d = count_q;
    ovf_o   = 1'b0;
    if (dec_i && !inc_i) begin
      count_d = count_q - W'(1);
    end else if (inc_i && !dec_i) begin
      if (count_q == MAX) ovf_o = 1'b1;
      else                count_d = count_q + W'(1);
    end
  end

  // NOTE: sequential state is updated with <= only, so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= MAX;
    else     count_q <= count_d;
  end

  assign count_o     = count_q;
  assign zero_next_o = (count_d == '0);

endmodule

// File: rtl/link_credit_tx.sv
// Credit-based link transmitter feeding a downstream buffer; registers flits onto the link.
// Optional sticky overflow flag and assertion under macro LINK_CREDIT_CHECK_EN.
module link_credit_tx
  import router_link_pkg::*;
#(
  parameter int unsigned buffer_depth = 8,
  parameter int unsigned buffer_width = FLIT_W,
  parameter int unsigned INIT_CYCLES  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [buffer_width-1:0]           in,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [buffer_width-1:0]           out,
  output logic                              produce,
  input  logic                              credit_return,
  output logic [credit_w(buffer_depth)-1:0] credits,
  output logic                              credit_err
);

  localparam int unsigned ICW = $clog2(INIT_CYCLES + 2);

  tx_state_t               state_q, state_d;
  logic [ICW-1:0]          init_cnt_q, init_cnt_d;
  logic [buffer_width-1:0] out_q;
  logic                    produce_q;
  logic                    send;
  logic                    zero_next;
  logic                    ovf;

  assign in_ready = (state_q == TX_RUN);
  assign send     = in_valid & in_ready;

  credit_counter #(.DEPTH(buffer_depth)) u_credits (
    .clk         (clk),
    .rst         (rst),
    .dec_i       (send),
    .inc_i       (credit_return),
    .count_o     (credits),
    .zero_next_o (zero_next),
    .ovf_o       (ovf)
  );

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      TX_INIT: begin
        if (init_cnt_q >= ICW'(INIT_CYCLES - 1)) state_d = TX_RUN;
        else                                     init_cnt_d = init_cnt_q + ICW'(1);
      end
      TX_RUN:     if (zero_next)  state_d = TX_BLOCKED;
      TX_BLOCKED: if (!zero_next) state_d = TX_RUN;
      default:    state_d = TX_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= TX_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Data register is reset too: the link must show out=0 while the partner is in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      produce_q <= 1'b0;
      out_q     <= '0;
    end else begin
      produce_q <= send;
      if (send) out_q <= in;
    end
  end

  assign out     = out_q;
  assign produce = produce_q;

`ifdef LINK_CREDIT_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      err_q <= 1'b0;
    else if (ovf) err_q <= 1'b1;
  end

  assign credit_err = err_q;

`ifndef SYNTHESIS
  a_no_credit_overflow : assert property (@(posedge clk) disable iff (rst) !ovf)
    else $error("link_credit_tx: credit return with all slots already free");
`endif
`else
  logic unused_ovf;
  assign unused_ovf = ovf;
  assign credit_err = 1'b0;
`endif

endmodule

// File: tb/tb_link_credit_tx.sv
// Scoreboard bench for link_credit_tx: sends are queued at the clock edge, a monitor pops and
// compares on every produce; directed credit scenarios plus a downstream-buffer soak.
module tb_link_credit_tx;
  import router_link_pkg::*;

`ifdef LINK_CREDIT_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  flit_t       in;
  logic        in_valid;
  logic        in_ready;
  flit_t       out;
  logic        produce;
  logic        credit_return;
  logic [3:0]  credits;
  logic        credit_err;

  int checks = 0;
  int errors = 0;

  flit_t exp_q[$];
  flit_t ds_q[$];

  link_credit_tx #(
    .buffer_depth (8),
    .buffer_width (64),
    .INIT_CYCLES  (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in            (in),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out           (out),
    .produce       (produce),
    .credit_return (credit_return),
    .credits       (credits),
    .credit_err    (credit_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected flit is whatever the bench drove when the handshake completed.
  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) exp_q.push_back(in);
  end

  always @(posedge rst) exp_q.delete();

  initial begin
    forever begin
      @(negedge clk);
      if (produce === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_produce: got out=%0h expected no produce (t=%0t)", out, $time);
        end else begin
          check("sb_flit", out, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int prod_cnt;
    int sent4;
    int cyc;

    rst           = 1'b1;
    in            = '0;
    in_valid      = 1'b1;
    credit_return = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready",   in_ready,   0);
    check("rst_credits",    credits,    7);
    check("rst_produce",    produce,    0);
    check("rst_out",        out,        0);
    check("rst_credit_err", credit_err, 0);

    // 1: INIT for two cycles, then seven back-to-back sends drain the credits
    rst      = 1'b0;
    in       = 64'hA000_0000_0000_0000;
    prod_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (produce) prod_cnt++;
      if (i == 1) check("t1_init_ready_c1", in_ready, 0);
      if (i == 2) check("t1_ready_c2",      in_ready, 1);
      if (i == 2) check("t1_credits_c2",    credits,  7);
      if (i == 5) check("t1_credits_c5",    credits,  4);
      if (i == 8) check("t1_ready_c8",      in_ready, 1);
      if (i == 9) check("t1_blocked_c9",    in_ready, 0);
      if (i == 9) check("t1_credits_c9",    credits,  0);
      in = 64'hA000_0000_0000_0000 + 64'(i);
    end
    check("t1_produce_cycles", prod_cnt, 7);
    check("t1_end_ready",      in_ready, 0);

    // 2: single credit at zero lets exactly one flit through
    credit_return = 1'b1;
    @(negedge clk);
    credit_return = 1'b0;
    check("t2_credits_1", credits,  1);
    check("t2_ready_1",   in_ready, 1);
    in = 64'hB000_0000_0000_0001;
    @(negedge clk);
    check("t2_credits_0", credits,  0);
    check("t2_ready_0",   in_ready, 0);
    check("t2_produce",   produce,  1);

    // 3: send and return in the same cycle leave credits unchanged
    in_valid      = 1'b0;
    credit_return = 1'b1;
    repeat (3) @(negedge clk);
    check("t3_credits_start", credits,  3);
    check("t3_ready_start",   in_ready, 1);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in = 64'hC000_0000_0000_0000 + 64'(i);
      @(negedge clk);
      check("t3_credits_hold", credits, 3);
    end

    // 5: return beyond max saturates
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_credits_max", credits, 7);
    @(negedge clk);
    credit_return = 1'b0;
    check("t5_credits_sat", credits,    7);
    check("t5_err",         credit_err, ERR_EXP);
    @(negedge clk);
    check("t5_err_sticky",  credit_err, ERR_EXP);

    // 6: reset while a flit is on the link with two credits left
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in = 64'hD000_0000_0000_0000 + 64'(i);
      @(negedge clk);
    end
    check("t6_credits_2", credits, 2);
    check("t6_produce_1", produce, 1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t6_produce_drop", produce,  0);
    check("t6_credits_max",  credits,  7);
    check("t6_ready_init",   in_ready, 0);
    check("t6_out_clear",    out,      0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_init_c1", in_ready, 0);
    @(negedge clk);
    check("t6_run_c2",  in_ready, 1);
    check("t6_credits_run", credits, 7);

    // 4: soak against a depth-8 downstream buffer consuming every other cycle
    sent4 = 0;
    cyc   = 0;
    while (sent4 < 1000 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      credit_return = 1'b0;
      if (produce) begin
        check("t4_ds_not_full", ds_q.size() < 7, 1);
        ds_q.push_back(out);
        sent4++;
      end
      if (cyc[0] && ds_q.size() > 0) begin
        void'(ds_q.pop_front());
        credit_return = 1'b1;
      end
      in_valid = 1'($urandom_range(0, 1));
      in       = {$urandom, $urandom};
    end
    in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      credit_return = 1'b0;
      if (produce) begin
        check("t4_ds_not_full", ds_q.size() < 7, 1);
        ds_q.push_back(out);
        sent4++;
      end
      if (ds_q.size() > 0) begin
        void'(ds_q.pop_front());
        credit_return = 1'b1;
      end
    end
    @(negedge clk);
    credit_return = 1'b0;
    @(negedge clk);
    check("t4_flits_sent",   sent4 >= 1000, 1);
    check("t4_credits_back", credits,       7);
    check("t4_sb_drained",   exp_q.size(),  0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
